// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// transfer size codes and the supported read-latency range.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Byte count of a transfer; codes 2 and 3 both mean a full port word.
   function automatic int size_bytes(input logic [1:0] size, input int word_bytes);
      case (size)
         SZ_BYTE: return 1;
         SZ_HALF: return 2;
         default: return word_bytes;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the fetch/load-store requesters, the controller and the
// byte-wide memory.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_flush;
   logic                  if_done;
   logic [DATA_WIDTH-1:0] if_inst;

   logic                  ls_req;
   logic                  ls_we;
   logic [1:0]            ls_size;
   logic                  ls_signed;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [DATA_WIDTH-1:0] ls_wdata;
   logic                  ls_done;
   logic [DATA_WIDTH-1:0] ls_rdata;

   logic [ADDR_WIDTH-1:0] mem_a;
   logic [7:0]            mem_dout;
   logic                  mem_wr;
   logic [7:0]            mem_din;

   logic                  busy;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
      input  mem_din,
      output if_done, if_inst, ls_done, ls_rdata,
      output mem_a, mem_dout, mem_wr, busy
   );

   modport master (
      output if_req, if_addr, if_flush,
      output ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
      output mem_din,
      input  if_done, if_inst, ls_done, ls_rdata,
      input  mem_a, mem_dout, mem_wr, busy
   );

endinterface

// File: rtl/mem_ext.sv
// Combinational load extension: keeps the low 8*N bits of the assembled word
// and zero- or sign-extends them to the full port width.
module mem_ext
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            size,
   input  logic                  sgn,
   input  logic [DATA_WIDTH-1:0] raw,
   output logic [DATA_WIDTH-1:0] ext
);

   always_comb begin
      ext = raw;
      case (size)
         SZ_BYTE: ext = {{(DATA_WIDTH-8){sgn & raw[7]}}, raw[7:0]};
         SZ_HALF: ext = {{(DATA_WIDTH-16){sgn & raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store ports onto a byte-wide memory,
// serialising each transfer one byte per cycle, little-endian.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LAT     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_ctrl_if.slave  bus
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(NB + RD_LAT_MAX + 1);

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [CNT_W-1:0]      nbytes_reg;
   logic [1:0]            size_reg;
   logic                  we_reg;
   logic                  signed_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  gnt_if_reg;
   logic                  last_if_reg;
   logic [DATA_WIDTH-1:0] if_inst_reg;
   logic [DATA_WIDTH-1:0] ls_rdata_reg;

   logic                  grant, grant_if;
   logic                  if_eff;
   logic [ADDR_WIDTH-1:0] mem_a_c;
   logic [7:0]            mem_dout_c;
   logic                  mem_wr_c;
   logic                  if_done_c, ls_done_c;
   logic [DATA_WIDTH-1:0] rbuf;
   logic [DATA_WIDTH-1:0] ext_word;

   // A flushed fetch request is simply not visible to the arbiter.
   assign if_eff = bus.if_req & ~bus.if_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      grant      = 1'b0;
      grant_if   = 1'b0;
      mem_a_c    = '0;
      mem_dout_c = '0;
      mem_wr_c   = 1'b0;
      if_done_c  = 1'b0;
      ls_done_c  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (if_eff && (!bus.ls_req || !last_if_reg)) begin
               grant    = 1'b1;
               grant_if = 1'b1;
            end else if (bus.ls_req) begin
               grant = 1'b1;
            end
            if (grant) begin
               cnt_next   = '0;
               state_next = (grant_if || !bus.ls_we) ? ST_READ : ST_WRITE;
            end
         end
         ST_READ: begin
            if (cnt_reg < nbytes_reg)
               mem_a_c = addr_reg + ADDR_WIDTH'(cnt_reg);
            if (gnt_if_reg && bus.if_flush)
               state_next = ST_IDLE;
            else if (cnt_reg == nbytes_reg + CNT_W'(RD_LAT - 1))
               state_next = ST_DONE;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         ST_WRITE: begin
            mem_a_c    = addr_reg + ADDR_WIDTH'(cnt_reg);
            mem_dout_c = 8'(wdata_reg >> {cnt_reg, 3'b000});
            mem_wr_c   = 1'b1;
            if (cnt_reg == nbytes_reg - CNT_W'(1))
               state_next = ST_DONE;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         ST_DONE: begin
            if_done_c  = gnt_if_reg & ~bus.if_flush;
            ls_done_c  = ~gnt_if_reg;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg     <= '0;
         nbytes_reg   <= '0;
         size_reg     <= SZ_BYTE;
         we_reg       <= 1'b0;
         signed_reg   <= 1'b0;
         wdata_reg    <= '0;
         gnt_if_reg   <= 1'b0;
         last_if_reg  <= 1'b1;
         if_inst_reg  <= '0;
         ls_rdata_reg <= '0;
      end else begin
         if (grant) begin
            gnt_if_reg  <= grant_if;
            last_if_reg <= grant_if;
            addr_reg    <= grant_if ? bus.if_addr : bus.ls_addr;
            nbytes_reg  <= grant_if ? CNT_W'(NB) : CNT_W'(size_bytes(bus.ls_size, NB));
            size_reg    <= grant_if ? SZ_WORD : bus.ls_size;
            we_reg      <= ~grant_if & bus.ls_we;
            signed_reg  <= ~grant_if & bus.ls_signed;
            wdata_reg   <= bus.ls_wdata;
         end
         if (if_done_c)
            if_inst_reg <= rbuf;
         if (ls_done_c && !we_reg)
            ls_rdata_reg <= ext_word;
      end
   end

   // Byte lane gi takes mem_din RD_LAT cycles after address base+gi was issued.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] byte_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            byte_reg <= '0;
         else if (grant)
            byte_reg <= '0;
         else if (state_reg == ST_READ && cnt_reg == CNT_W'(gi + RD_LAT))
            byte_reg <= bus.mem_din;
      end
      assign rbuf[8*gi +: 8] = byte_reg;
   end

   mem_ext #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ext (
      .size (size_reg),
      .sgn  (signed_reg),
      .raw  (rbuf),
      .ext  (ext_word)
   );

   // Data outputs show the new word during the done pulse, then hold it.
   assign bus.if_inst  = if_done_c ? rbuf : if_inst_reg;
   assign bus.ls_rdata = (ls_done_c && !we_reg) ? ext_word : ls_rdata_reg;
   assign bus.if_done  = if_done_c;
   assign bus.ls_done  = ls_done_c;
   assign bus.mem_a    = mem_a_c;
   assign bus.mem_dout = mem_dout_c;
   assign bus.mem_wr   = mem_wr_c;
   assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized checks of mem_ctrl against a byte-addressed
// reference memory with little-endian load/store rules.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW     = 17;
   localparam int DW     = 32;
   localparam int RD_LAT = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory: bytes never written read back as a fixed hash of the address.
   logic [7:0]    mem     [0:(1<<AW)-1];
   bit            written [0:(1<<AW)-1];
   logic [7:0]    rd_pipe [RD_LAT];
   logic [AW-1:0] log_a   [64];
   logic [7:0]    log_d   [64];
   int            wr_count    = 0;
   int            if_done_cnt = 0;
   int            ls_done_cnt = 0;

   function automatic logic [7:0] hash8(input logic [AW-1:0] a);
      return a[7:0] ^ a[16:9] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
      return written[a] ? mem[a] : hash8(a);
   endfunction

   always @(posedge clk) begin
      rd_pipe[0] <= mem_rd(bus.mem_a);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (bus.mem_wr) begin
         mem[bus.mem_a]        <= bus.mem_dout;
         written[bus.mem_a]    <= 1'b1;
         log_a[wr_count[5:0]]  <= bus.mem_a;
         log_d[wr_count[5:0]]  <= bus.mem_dout;
         wr_count              <= wr_count + 1;
      end
      if (bus.if_done) if_done_cnt <= if_done_cnt + 1;
      if (bus.ls_done) ls_done_cnt <= ls_done_cnt + 1;
   end
   assign bus.mem_din = rd_pipe[RD_LAT-1];

   // Reference model state
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : hash8(a);
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : DW / 8;
   endfunction

   function automatic logic [31:0] exp_load(input logic [AW-1:0] a, input logic [1:0] sz, input logic sg);
      int n;
      logic [31:0] v;
      logic [AW-1:0] ak;
      n = nbytes(sz);
      v = '0;
      for (int k = 0; k < n; k++) begin
         ak = a + AW'(k);
         v  = v | (32'(ref_rd(ak)) << (8 * k));
      end
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic ref_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] wd, input int upto);
      logic [AW-1:0] ak;
      for (int k = 0; k < nbytes(sz) && k < upto; k++) begin
         ak = a + AW'(k);
         ref_mem[int'(ak)] = wd[8*k +: 8];
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                         : AW'(32'h1FFF0 + $urandom_range(0, 15));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_ls(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] a, input logic [31:0] wd, output logic [31:0] rd);
      int lat, wc0, n;
      logic [31:0] prev_if;
      n = nbytes(sz);
      @(negedge clk);
      wc0     = wr_count;
      prev_if = bus.if_inst;
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = sz; bus.ls_signed = sg;
      bus.ls_addr = a; bus.ls_wdata = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.ls_we = 1'($urandom); bus.ls_size = 2'($urandom); bus.ls_signed = 1'($urandom);
            bus.ls_addr = AW'($urandom); bus.ls_wdata = $urandom;
         end
      end while (!bus.ls_done && lat < 40);
      rd = bus.ls_rdata;
      chk("ls_done_seen", 32'(bus.ls_done), 32'd1);
      bus.ls_req = 1'b0;
      chk("if_inst_hold", bus.if_inst, prev_if);
      if (we) begin
         ref_store(a, sz, wd, n);
         chk("st_latency", lat, n + 1);
         chk("st_wr_cycles", wr_count - wc0, n);
      end else begin
         chk("ld_latency", lat, n + RD_LAT + 1);
         chk("ld_data", rd, exp_load(a, sz, sg));
      end
      $display("[TB] LS we=%0d size=%0d sgn=%0d addr=%05h wdata=%08h rdata=%08h lat=%0d",
               we, sz, sg, a, wd, rd, lat);
   endtask

   task automatic do_if(input logic [AW-1:0] a);
      int lat;
      logic [31:0] prev_ls;
      @(negedge clk);
      prev_ls = bus.ls_rdata;
      bus.if_req = 1'b1; bus.if_addr = a;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.if_addr = AW'($urandom);
      end while (!bus.if_done && lat < 40);
      chk("if_done_seen", 32'(bus.if_done), 32'd1);
      chk("if_latency", lat, DW / 8 + RD_LAT + 1);
      chk("if_inst", bus.if_inst, exp_load(a, SZ_WORD, 1'b0));
      chk("ls_rdata_hold", bus.ls_rdata, prev_ls);
      $display("[TB] IF addr=%05h inst=%08h lat=%0d", a, bus.if_inst, lat);
      bus.if_req = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, prev_inst;
      int cnt, ne, d0, wc0;
      int ev_port [3];
      int ev_time [3];
      logic [31:0] ev_data [3];

      bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
      bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = '0; bus.ls_signed = 0;
      bus.ls_addr = '0; bus.ls_wdata = '0;

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_a", 32'(bus.mem_a), 0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 0);
      chk("rst_if_done", 32'(bus.if_done), 0);
      chk("rst_ls_done", 32'(bus.ls_done), 0);
      chk("rst_if_inst", bus.if_inst, 0);
      chk("rst_ls_rdata", bus.ls_rdata, 0);
      chk("rst_busy", 32'(bus.busy), 0);

      // Contention from reset: LS, then IF, then LS again.
      bus.if_req = 1; bus.if_addr = 17'h00100;
      bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = SZ_WORD; bus.ls_addr = 17'h00010;
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0; ne = 0;
      while (ne < 3 && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (bus.ls_done && ne < 3) begin
            ev_port[ne] = 0; ev_time[ne] = cnt; ev_data[ne] = bus.ls_rdata; ne++;
         end
         if (bus.if_done && ne < 3) begin
            ev_port[ne] = 1; ev_time[ne] = cnt; ev_data[ne] = bus.if_inst; ne++;
            bus.if_req = 0;
         end
      end
      bus.ls_req = 0; bus.if_req = 0;
      chk("arb_events", ne, 3);
      if (ne == 3) begin
         chk("arb_first_ls", ev_port[0], 0);
         chk("arb_then_if", ev_port[1], 1);
         chk("arb_then_ls", ev_port[2], 0);
         chk("arb_t0", ev_time[0], 6);
         chk("arb_t1", ev_time[1], 13);
         chk("arb_t2", ev_time[2], 20);
         chk("arb_ls_data", ev_data[0], exp_load(17'h00010, SZ_WORD, 1'b0));
         chk("arb_if_data", ev_data[1], exp_load(17'h00100, SZ_WORD, 1'b0));
         chk("arb_ls_data2", ev_data[2], exp_load(17'h00010, SZ_WORD, 1'b0));
      end
      $display("[TB] ARB events=%0d t=%0d/%0d/%0d", ne, ev_time[0], ev_time[1], ev_time[2]);

      // Word load of 11 22 33 44
      do_ls(1'b1, SZ_WORD, 1'b0, 17'h00010, 32'h44332211, rd);
      do_ls(1'b0, SZ_WORD, 1'b0, 17'h00010, 32'h0, rd);
      chk("word_load", rd, 32'h44332211);

      // Signed and unsigned byte loads of 0x80
      do_ls(1'b1, SZ_BYTE, 1'b0, 17'h00005, 32'h12345680, rd);
      do_ls(1'b0, SZ_BYTE, 1'b1, 17'h00005, 32'h0, rd);
      chk("byte_signed", rd, 32'hFFFFFF80);
      do_ls(1'b0, SZ_BYTE, 1'b0, 17'h00005, 32'h0, rd);
      chk("byte_unsigned", rd, 32'h00000080);

      // Half store across the top of the address space
      wc0 = wr_count;
      do_ls(1'b1, SZ_HALF, 1'b0, 17'h1FFFF, 32'hA5A5BEEF, rd);
      chk("wrap_a0", 32'(log_a[wc0[5:0]]), 32'h1FFFF);
      chk("wrap_d0", 32'(log_d[wc0[5:0]]), 32'hEF);
      chk("wrap_a1", 32'(log_a[6'(wc0 + 1)]), 32'h00000);
      chk("wrap_d1", 32'(log_d[6'(wc0 + 1)]), 32'hBE);
      do_ls(1'b0, SZ_HALF, 1'b0, 17'h1FFFF, 32'h0, rd);
      chk("wrap_load", rd, 32'h0000BEEF);

      // Flush two cycles into a fetch
      @(negedge clk);
      d0 = if_done_cnt;
      bus.if_req = 1; bus.if_addr = 17'h00040;
      repeat (2) @(negedge clk);
      bus.if_flush = 1; bus.if_req = 0;
      @(negedge clk);
      chk("flush_busy", 32'(bus.busy), 0);
      bus.if_flush = 0;
      repeat (8) @(negedge clk);
      chk("flush_no_done", if_done_cnt - d0, 0);
      $display("[TB] FLUSH read: if_done count delta=%0d", if_done_cnt - d0);
      do_ls(1'b0, SZ_WORD, 1'b0, 17'h00010, 32'h0, rd);
      chk("flush_then_ls", rd, 32'h44332211);

      // Flush during the done cycle of a fetch
      @(negedge clk);
      prev_inst = bus.if_inst;
      d0 = if_done_cnt;
      bus.if_req = 1; bus.if_addr = 17'h00010;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!bus.if_done && cnt < 40);
      chk("dflush_seen", 32'(bus.if_done), 1);
      bus.if_flush = 1;
      #1;
      chk("dflush_done_low", 32'(bus.if_done), 0);
      chk("dflush_inst_hold", bus.if_inst, prev_inst);
      bus.if_req = 0;
      @(negedge clk);
      bus.if_flush = 0;
      chk("dflush_busy", 32'(bus.busy), 0);
      chk("dflush_no_done", if_done_cnt - d0, 0);
      $display("[TB] FLUSH done: if_inst=%08h", bus.if_inst);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            do_if(rand_addr());
         else
            do_ls(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom, rd);
      end

      // Reset during a word store after two bytes
      @(negedge clk);
      wc0 = wr_count;
      d0  = ls_done_cnt;
      bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = SZ_WORD; bus.ls_signed = 0;
      bus.ls_addr = 17'h00020; bus.ls_wdata = 32'hCAFEF00D;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (wr_count - wc0 < 2 && cnt < 20);
      chk("rst_mid_writes", wr_count - wc0, 2);
      rst_n = 1'b0;
      #1;
      chk("rstm_mem_wr", 32'(bus.mem_wr), 0);
      chk("rstm_mem_a", 32'(bus.mem_a), 0);
      chk("rstm_mem_dout", 32'(bus.mem_dout), 0);
      chk("rstm_busy", 32'(bus.busy), 0);
      chk("rstm_ls_done", 32'(bus.ls_done), 0);
      chk("rstm_if_done", 32'(bus.if_done), 0);
      chk("rstm_if_inst", bus.if_inst, 0);
      chk("rstm_ls_rdata", bus.ls_rdata, 0);
      bus.ls_req = 0;
      ref_store(17'h00020, SZ_WORD, 32'hCAFEF00D, 2);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rstm_no_ls_done", ls_done_cnt - d0, 0);
      chk("rstm_partial", wr_count - wc0, 2);
      $display("[TB] RESET mid-store: bytes written=%0d", wr_count - wc0);
      do_ls(1'b0, SZ_WORD, 1'b0, 17'h00020, 32'h0, rd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 17, memory byte-address width.
- DATA_WIDTH, 32, port word width, a multiple of 8.
- RD_LAT, 1, cycles from address presented to read byte valid on mem_din (1..3).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- if_req, in, 1, instruction fetch request, held high until if_done.
- if_addr, in, ADDR_WIDTH, fetch byte address.
- if_flush, in, 1, abandon any granted or in-flight fetch.
- if_done, out, 1, one-cycle pulse: if_inst valid.
- if_inst, out, DATA_WIDTH, fetched word, little-endian.
- ls_req, in, 1, load/store request, held high until ls_done.
- ls_we, in, 1, 1 = store, 0 = load.
- ls_size, in, 2, 0 = byte, 1 = half, 2/3 = full word.
- ls_signed, in, 1, sign-extend loads narrower than DATA_WIDTH.
- ls_addr, in, ADDR_WIDTH, data byte address.
- ls_wdata, in, DATA_WIDTH, store data; low bytes used.
- ls_done, out, 1, one-cycle pulse: load data valid or store committed.
- ls_rdata, out, DATA_WIDTH, extended load result.
- mem_a, out, ADDR_WIDTH, byte address to memory.
- mem_dout, out, 8, write byte.
- mem_wr, out, 1, 1 = write mem_dout at mem_a this cycle.
- mem_din, in, 8, read byte, valid RD_LAT cycles after its address.
- busy, out, 1, high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, READ, WRITE, DONE; N = transfer byte count (1, 2 or DATA_WIDTH/8).
REQ-004 In IDLE, requests SHALL be sampled; grant goes to the only requester, or to the port not granted last when both request; after reset, last-granted = IF, so LS wins first contention.
REQ-005 On grant, address, size, we, signed and wdata SHALL be latched; later changes to port inputs SHALL NOT affect the transfer.
REQ-006 READ SHALL drive mem_a = base+k, mem_wr = 0, for k = 0..N-1 on consecutive cycles.
REQ-007 READ SHALL capture mem_din into byte k RD_LAT cycles later, lasting N+RD_LAT cycles, then enter DONE.
REQ-008 WRITE SHALL drive mem_a = base+k, mem_dout = byte k of wdata, mem_wr = 1 for k = 0..N-1, then enter DONE; mem_wr SHALL be 0 in all other states.
REQ-009 Address increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-010 DONE SHALL last exactly one cycle, pulse the granted port's done, update its data output, and return to IDLE.
REQ-011 The IDLE cycle after DONE SHALL be able to grant a new request, giving a minimum request-to-request spacing of N+RD_LAT+2 cycles for reads.
REQ-012 Load results SHALL be zero-extended, or sign-extended from bit 8N-1 when ls_signed = 1; if_inst SHALL always be a full word.
REQ-013 if_inst and ls_rdata SHALL hold their value until the next done on the same port.
REQ-014 if_flush in IDLE with IF about to be granted SHALL suppress the grant.
REQ-015 if_flush during an IF READ SHALL return to IDLE next cycle with no if_done.
REQ-016 if_flush in the DONE cycle of an IF SHALL suppress that if_done.
REQ-017 if_flush SHALL have no effect on LS transfers.
REQ-018 A store SHALL never be aborted once granted.

Reset
REQ-019 On rst_n low, immediately and asynchronously:
- state = IDLE, last-granted = IF.
- all outputs 0: mem_a, mem_dout, mem_wr, if_done, ls_done, if_inst, ls_rdata, busy.
REQ-020 Reset mid-transfer SHALL discard the transfer with no done pulse; a store may be partially written.
REQ-021 The first grant SHALL occur no earlier than the first rising edge after rst_n rises.

Structure
REQ-022 State encodings, size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and the RD_LAT range SHALL live in the shared defines package.
REQ-023 Load extension SHALL be a sub-module, mem_ext, that is combinational: size, signed and raw word in; extended word out.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Word load, addr 0x00010, memory 0x10..0x13 = 11 22 33 44, RD_LAT = 1 -> ls_rdata 0x44332211; ls_done 6 cycles after grant.
- Byte load signed, addr 0x00005 holding 0x80 -> ls_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0xA5A5BEEF, addr 0x1FFFF -> writes EF at 0x1FFFF and BE at 0x00000 (wrap); exactly 2 mem_wr cycles.
- if_req and ls_req both high from reset -> LS served first, then IF, then LS again if still held.
- if_flush asserted 2 cycles into a fetch -> no if_done; busy low the next cycle; subsequent ls_req granted.
- rst_n dropped mid word-store after 2 bytes -> mem_wr 0 immediately, no ls_done, all outputs 0.
